// File: rtl/tp_lookup_pkg.sv
// Shared definitions for the track-parameter lookup sequencer: FSM state encoding and default widths.
package tp_lookup_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

   localparam int DEF_RAM_WIDTH     = 18;
   localparam int DEF_RAM_ADDR_BITS = 5;
   localparam int DEF_TAG_WIDTH     = 32;
   localparam int DEF_FIFO_DEPTH    = 4;

endpackage

// File: rtl/tp_lookup_fifo.sv
// Synchronous FIFO with occupancy count; storage is not reset, only pointers and count.
module tp_lookup_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/tp_lookup_sequencer.sv
// Issue stage for TP_lookup_memory: key->address, tag alignment with 1-cycle memory output, output FIFO.
// Optional statistics counters are built when TP_LOOKUP_STATS_EN is defined.
module tp_lookup_sequencer
   import tp_lookup_pkg::*;
#(
   parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
   parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
   parameter int TAG_WIDTH     = DEF_TAG_WIDTH,
   parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   input  logic [RAM_ADDR_BITS-1:0] IN_KEY,
   input  logic [TAG_WIDTH-1:0]     IN_TAG,
   input  logic                     IN_LAST,
   output logic [RAM_ADDR_BITS-1:0] MEM_RD_A,
   output logic                     MEM_RD_EN,
   input  logic [RAM_WIDTH-1:0]     MEM_DO,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [RAM_WIDTH-1:0]     OUT_DATA,
   output logic [TAG_WIDTH-1:0]     OUT_TAG,
   output logic                     OUT_LAST
`ifdef TP_LOOKUP_STATS_EN
  ,input  logic                     STAT_CLR,
   output logic [31:0]              STAT_LOOKUPS,
   output logic [31:0]              STAT_STALLS
`endif
);

   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int CW1 = CW + 1;
   localparam int FW  = RAM_WIDTH + TAG_WIDTH + 1;
   localparam logic [CW:0] DEPTH_L = CW1'(FIFO_DEPTH);

   state_t                 state_q, state_d;
   logic                   accept, pop, credit_ok;
   logic                   s1_vld_q;
   logic [TAG_WIDTH-1:0]   s1_tag_q;
   logic                   s1_last_q;
   logic [CW-1:0]          fifo_count;
   logic [CW:0]            occupancy;
   logic [FW-1:0]          fifo_dout;
   logic [RAM_WIDTH-1:0]   head_data;
   logic [TAG_WIDTH-1:0]   head_tag;
   logic                   head_last;
   logic                   fifo_nempty;

   // Credit counts every stub accepted but not yet popped, so the FIFO cannot overflow.
   assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s1_vld_q};
   assign credit_ok = occupancy < DEPTH_L;

   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = IN_LAST ? ST_DRAIN : ST_RUN;
         ST_RUN:   if (accept && IN_LAST) state_d = ST_DRAIN;
         ST_DRAIN: if (pop && OUT_LAST) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      IN_READY = !RST && (state_q != ST_DRAIN) && credit_ok;
   end

   assign accept    = IN_VALID && IN_READY;
   assign MEM_RD_EN = accept;
   assign MEM_RD_A  = RST ? '0 : IN_KEY;

   // s1: tag waits here while the memory registers its read
   always_ff @(posedge CLK) begin
      if (RST) s1_vld_q <= 1'b0;
      else     s1_vld_q <= accept;
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         s1_tag_q  <= IN_TAG;
         s1_last_q <= IN_LAST;
      end
   end

   tp_lookup_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (s1_vld_q),
      .din_i   ({MEM_DO, s1_tag_q, s1_last_q}),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .count_o (fifo_count)
   );

   assign {head_data, head_tag, head_last} = fifo_dout;
   assign fifo_nempty = (fifo_count != '0);
   assign pop         = OUT_VALID && OUT_READY;

   // Outputs read zero whenever the FIFO is empty, which also covers the post-reset values.
   assign OUT_VALID = fifo_nempty;
   assign OUT_DATA  = fifo_nempty ? head_data : '0;
   assign OUT_TAG   = fifo_nempty ? head_tag  : '0;
   assign OUT_LAST  = fifo_nempty && head_last;

`ifdef TP_LOOKUP_STATS_EN
   logic [31:0] lookups_q, stalls_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge CLK) begin
      if (RST || STAT_CLR) begin
         lookups_q <= '0;
         stalls_q  <= '0;
      end else begin
         if (accept)                lookups_q <= sat_inc(lookups_q);
         if (IN_VALID && !IN_READY) stalls_q  <= sat_inc(stalls_q);
      end
   end

   assign STAT_LOOKUPS = lookups_q;
   assign STAT_STALLS  = stalls_q;
`endif

endmodule

// File: tb/tb_tp_lookup_sequencer.sv
// Self-checking bench for tp_lookup_sequencer against a queue-based reference model; stats test under TP_LOOKUP_STATS_EN.
module tb_tp_lookup_sequencer;

   localparam int RW = 18;
   localparam int AB = 5;
   localparam int TW = 32;
   localparam int FD = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          IN_VALID;
   logic          IN_READY;
   logic [AB-1:0] IN_KEY;
   logic [TW-1:0] IN_TAG;
   logic          IN_LAST;
   logic [AB-1:0] MEM_RD_A;
   logic          MEM_RD_EN;
   logic [RW-1:0] MEM_DO;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic [RW-1:0] OUT_DATA;
   logic [TW-1:0] OUT_TAG;
   logic          OUT_LAST;
   logic          STAT_CLR;
`ifdef TP_LOOKUP_STATS_EN
   logic [31:0]   STAT_LOOKUPS;
   logic [31:0]   STAT_STALLS;
`endif

   always #5 CLK = ~CLK;

   tp_lookup_sequencer #(
      .RAM_WIDTH     (RW),
      .RAM_ADDR_BITS (AB),
      .TAG_WIDTH     (TW),
      .FIFO_DEPTH    (FD)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_KEY    (IN_KEY),
      .IN_TAG    (IN_TAG),
      .IN_LAST   (IN_LAST),
      .MEM_RD_A  (MEM_RD_A),
      .MEM_RD_EN (MEM_RD_EN),
      .MEM_DO    (MEM_DO),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_DATA  (OUT_DATA),
      .OUT_TAG   (OUT_TAG),
      .OUT_LAST  (OUT_LAST)
`ifdef TP_LOOKUP_STATS_EN
     ,.STAT_CLR     (STAT_CLR),
      .STAT_LOOKUPS (STAT_LOOKUPS),
      .STAT_STALLS  (STAT_STALLS)
`endif
   );

   // Lookup memory: registered read every cycle, single write port.
   logic [RW-1:0] ram [32];
   logic          mem_we;
   logic [AB-1:0] mem_wa;
   logic [RW-1:0] mem_wd;

   always @(posedge CLK) begin
      MEM_DO <= ram[MEM_RD_A];
      if (mem_we) ram[mem_wa] <= mem_wd;
   end

   typedef struct {
      logic [RW-1:0] d;
      logic [TW-1:0] t;
      logic          l;
      int            c;
   } item_t;

   item_t         q[$];
   logic [RW-1:0] ref_ram [32];
   bit            drain;
   int            cyc;
   int            checks;
   int            errors;
   bit            last_acc;
   int            acc_cnt;
   int unsigned   m_look;
   int unsigned   m_stall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, compare against the model, advance the model, move to next negedge.
   task automatic tick(input bit rst, input bit v, input logic [AB-1:0] k, input logic [TW-1:0] tg,
                       input bit l, input bit ordy, input bit we = 1'b0,
                       input logic [AB-1:0] wa = '0, input logic [RW-1:0] wd = '0, input bit clr = 1'b0);
      bit    exp_rdy;
      bit    exp_vld;
      item_t h;
      RST = rst; IN_VALID = v; IN_KEY = k; IN_TAG = tg; IN_LAST = l; OUT_READY = ordy;
      mem_we = we; mem_wa = wa; mem_wd = wd; STAT_CLR = clr;
      #1;
      exp_rdy = !rst && !drain && (q.size() < FD);
      exp_vld = (q.size() > 0) && (cyc >= q[0].c + 2);
      chk("in_ready", IN_READY, exp_rdy);
      chk("mem_rd_en", MEM_RD_EN, v && exp_rdy);
      if (v && exp_rdy) chk("mem_rd_a", MEM_RD_A, k);
      chk("out_valid", OUT_VALID, exp_vld);
      if (exp_vld) begin
         chk("out_data", OUT_DATA, q[0].d);
         chk("out_tag", OUT_TAG, q[0].t);
         chk("out_last", OUT_LAST, q[0].l);
      end
`ifdef TP_LOOKUP_STATS_EN
      chk("stat_lookups", STAT_LOOKUPS, m_look);
      chk("stat_stalls", STAT_STALLS, m_stall);
`endif
      last_acc = v && IN_READY;
      if (last_acc) acc_cnt++;
      if (exp_vld && ordy) begin
         h = q.pop_front();
         if (h.l) drain = 1'b0;
      end
      if (v && exp_rdy) begin
         q.push_back('{d: ref_ram[k], t: tg, l: l, c: cyc});
         if (l) drain = 1'b1;
      end
      if (rst || clr) begin
         m_look = 0; m_stall = 0;
      end else begin
         if (v && exp_rdy)  m_look++;
         if (v && !exp_rdy) m_stall++;
      end
      if (we) ref_ram[wa] = wd;
      if (rst) begin
         q.delete();
         drain = 1'b0;
      end
      cyc++;
      @(negedge CLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      checks = 0; errors = 0; cyc = 0; drain = 1'b0; acc_cnt = 0; m_look = 0; m_stall = 0;
      RST = 1'b1; IN_VALID = 1'b0; IN_KEY = '0; IN_TAG = '0; IN_LAST = 1'b0;
      OUT_READY = 1'b0; STAT_CLR = 1'b0; mem_we = 1'b0; mem_wa = '0; mem_wd = '0;

      // Preload RAM[k] = k*3 while reset is held.
      for (int k = 0; k < 32; k++) begin
         mem_we = 1'b1; mem_wa = AB'(k); mem_wd = RW'(k * 3);
         ref_ram[k] = RW'(k * 3);
         @(negedge CLK);
      end
      mem_we = 1'b0;

      // Reset state, with a stub offered while RST is still high.
      IN_VALID = 1'b1; IN_KEY = 5'h1f;
      #1;
      chk("rst_in_ready", IN_READY, 1'b0);
      chk("rst_mem_rd_en", MEM_RD_EN, 1'b0);
      chk("rst_mem_rd_a", MEM_RD_A, 0);
      chk("rst_out_valid", OUT_VALID, 1'b0);
      chk("rst_out_data", OUT_DATA, 0);
      chk("rst_out_tag", OUT_TAG, 0);
      chk("rst_out_last", OUT_LAST, 1'b0);
      @(negedge CLK);

      // 1: stream keys 0..31 at full rate.
      acc_cnt = 0;
      for (int k = 0; k < 32; k++) tick(0, 1, AB'(k), $urandom, 0, 1);
      chk("t1_accepts", acc_cnt, 32);
      repeat (4) tick(0, 0, '0, '0, 0, 1);

      // 2: backpressure with valid held high.
      acc_cnt = 0;
      repeat (8) tick(0, 1, AB'($urandom), $urandom, 0, 0);
      chk("t2_accepts", acc_cnt, 4);
      repeat (6) tick(0, 0, '0, '0, 0, 1);

      // 3: three-stub event, then a single-stub event waiting behind it.
      tick(0, 1, 5'd7, 32'hA001, 0, 1);
      tick(0, 1, 5'd8, 32'hA002, 0, 1);
      tick(0, 1, 5'd9, 32'hA003, 1, 1);
      for (i = 0; i < 20; i++) begin
         tick(0, 1, 5'd10, 32'hB000, 1, 1);
         if (last_acc) break;
      end
      chk("t3_next_accepted", last_acc, 1'b1);
      chk("t3_wait_cycles", i, 2);
      repeat (4) tick(0, 0, '0, '0, 0, 1);

      // 4: reset with two stubs in flight.
      tick(0, 1, 5'd3, 32'hC001, 0, 0);
      tick(0, 1, 5'd4, 32'hC002, 0, 0);
      tick(1, 0, '0, '0, 0, 0);
      repeat (5) tick(0, 0, '0, '0, 0, 1);
      tick(0, 1, 5'd11, 32'hC003, 0, 1);
      tick(0, 1, 5'd12, 32'hC004, 1, 1);
      repeat (4) tick(0, 0, '0, '0, 0, 1);

      // 5: write key 5 two cycles before its lookup.
      tick(0, 0, '0, '0, 0, 1, 1'b1, 5'd5, 18'h2ABCD);
      tick(0, 0, '0, '0, 0, 1);
      tick(0, 1, 5'd5, 32'hD005, 1, 1);
      repeat (4) tick(0, 0, '0, '0, 0, 1);

      // Randomised traffic with occasional memory writes.
      for (int n = 0; n < 400; n++) begin
         tick(0, ($urandom % 4) != 0, AB'($urandom), $urandom, ($urandom % 10) == 0,
              ($urandom % 3) != 0, ($urandom % 16) == 0, AB'($urandom), RW'($urandom));
      end
      for (i = 0; i < 30; i++) begin
         tick(0, 1, AB'($urandom), $urandom, 1, 1);
         if (last_acc) break;
      end
      chk("rand_final_last_accepted", last_acc, 1'b1);
      repeat (6) tick(0, 0, '0, '0, 0, 1);

`ifdef TP_LOOKUP_STATS_EN
      // 6: 10 accepts and 7 stalled cycles, then clear.
      tick(0, 0, '0, '0, 0, 1, 1'b0, '0, '0, 1'b1);
      repeat (11) tick(0, 1, AB'($urandom), $urandom, 0, 0);
      repeat (6) tick(0, 0, '0, '0, 0, 1);
      repeat (6) tick(0, 1, AB'($urandom), $urandom, 0, 1);
      tick(0, 0, '0, '0, 0, 1);
      chk("t6_lookups", STAT_LOOKUPS, 10);
      chk("t6_stalls", STAT_STALLS, 7);
      tick(0, 0, '0, '0, 0, 1, 1'b0, '0, '0, 1'b1);
      chk("t6_clr_lookups", STAT_LOOKUPS, 0);
      chk("t6_clr_stalls", STAT_STALLS, 0);
      tick(0, 1, 5'd1, 32'hE001, 1, 1);
      repeat (4) tick(0, 0, '0, '0, 0, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
